// File: rtl/irq_controller12_if.sv
// irq_controller12_if
// Bundles the processor-side signals of the interrupt controller: the register
// access bus and the interrupt request/acknowledge handshake.
//
// Signals:
//   reg_addr   [2:0]  register select
//   reg_wdata  [11:0] register write data
//   reg_we            register write strobe
//   reg_rdata  [11:0] register read data (combinational from reg_addr)
//   irq_ack           one-cycle pulse, processor has entered interrupt mode
//   irq_eoi           one-cycle pulse, end of interrupt service
//   irq_req           interrupt mode request to the processor
//   irq_vector [4:0]  index of the channel being requested/serviced
//
// Modports:
//   master - processor side (drives the bus and the ack/eoi pulses)
//   slave  - controller side (drives read data, request and vector)
interface irq_controller12_if;
    logic [2:0]  reg_addr;
    logic [11:0] reg_wdata;
    logic        reg_we;
    logic [11:0] reg_rdata;
    logic        irq_ack;
    logic        irq_eoi;
    logic        irq_req;
    logic [4:0]  irq_vector;

    modport master (
        output reg_addr, reg_wdata, reg_we, irq_ack, irq_eoi,
        input  reg_rdata, irq_req, irq_vector
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_we, irq_ack, irq_eoi,
        output reg_rdata, irq_req, irq_vector
    );
endinterface

// File: rtl/irq_controller12.sv
// irq_controller12
// Prioritising interrupt controller for up to 24 channels. Each raw line is
// synchronised, turned into a pending bit (level or rising-edge per channel),
// qualified by per-channel enables and a global enable, and the lowest-numbered
// qualifying channel is presented to the processor through a three-state
// IDLE/REQUEST/SERVICE handshake.
//
// Parameters:
//   N_IRQ     number of channels, 1..24
//   EDGE_MASK bit i = 1 makes channel i rising-edge triggered, 0 level
//
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   asynchronous active-low reset
//   irq   raw interrupt lines, asynchronous to clk
//   bus   processor-side interface (register bus plus req/ack/eoi/vector)
//
// Register map (12-bit):
//   0 PEND_L  pending ch 0-11, write-1-to-clear (edge channels only)
//   1 PEND_H  pending ch 12-23, write-1-to-clear (edge channels only)
//   2 EN_L    enable ch 0-11
//   3 EN_H    enable ch 12-23
//   4 VECTOR  current vector, 12'o7777 while idle
//   5 CTRL    bit 0 global enable
//   6,7       read 0, writes ignored
module irq_controller12 #(
    parameter int          N_IRQ     = 24,
    parameter logic [23:0] EDGE_MASK = 24'o00000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IRQ-1:0]      irq,
    irq_controller12_if.slave     bus
);

    // Channels at or above N_IRQ are forced to zero everywhere through this mask.
    localparam logic [24:0] TOP_BIT    = 25'd1 << N_IRQ;
    localparam logic [23:0] VALID_MASK = 24'(TOP_BIT - 25'd1);
    localparam logic [23:0] EDGE_CH    = EDGE_MASK & VALID_MASK;
    localparam logic [23:0] LEVEL_CH   = ~EDGE_MASK & VALID_MASK;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    logic [23:0] irq_ext;
    logic [23:0] sync1_q, sync1_d;
    logic [23:0] sync2_q, sync2_d;
    logic [23:0] prev_q, prev_d;
    logic [1:0]  arm_cnt_q, arm_cnt_d;
    logic [23:0] pend_q, pend_d;
    logic [23:0] en_q, en_d;
    logic        ctrl_q, ctrl_d;
    state_t      state_q, state_d;
    logic        irq_req_q, irq_req_d;
    logic [4:0]  vector_q, vector_d;

    logic        armed;
    logic [23:0] rise;
    logic [23:0] qual;
    logic        req_cond;
    logic [4:0]  win_idx;
    logic [23:0] pend_w1c;
    logic [23:0] ack_clr;
    logic [11:0] rdata;

    assign irq_ext = 24'(irq);

    // Edge detection is held off for two cycles after reset. During that time
    // prev tracks the value sync2 is about to take, so a line that was already
    // high when reset released never looks like a fresh rising edge.
    always_comb begin
        armed     = (arm_cnt_q == 2'd2);
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
        sync1_d   = irq_ext & VALID_MASK;
        sync2_d   = sync1_q;
        prev_d    = armed ? sync2_q : sync1_q;
        rise      = sync2_q & ~prev_q & {24{armed}};
    end

    // Pending, enable and control registers. An edge channel's pending bit is
    // cleared by a W1C write or by the processor acknowledging that channel,
    // but a new edge in the same cycle wins over the clear.
    always_comb begin
        pend_w1c = '0;
        en_d     = en_q;
        ctrl_d   = ctrl_q;
        if (bus.reg_we) begin
            case (bus.reg_addr)
                3'd0:    pend_w1c[11:0]  = bus.reg_wdata;
                3'd1:    pend_w1c[23:12] = bus.reg_wdata;
                3'd2:    en_d[11:0]      = bus.reg_wdata;
                3'd3:    en_d[23:12]     = bus.reg_wdata;
                3'd5:    ctrl_d          = bus.reg_wdata[0];
                default: ;
            endcase
        end
        en_d = en_d & VALID_MASK;

        ack_clr = '0;
        if (state_q == REQUEST && bus.irq_ack) begin
            ack_clr = 24'd1 << vector_q;
        end

        pend_d = (LEVEL_CH & sync2_q)
               | (EDGE_CH & (rise | (pend_q & ~(pend_w1c | ack_clr))));
    end

    // Lowest-numbered qualifying channel wins; scanning downward lets the
    // lowest index overwrite any higher one.
    always_comb begin
        qual     = pend_q & en_q & VALID_MASK;
        req_cond = ctrl_q & (|qual);
        win_idx  = '0;
        for (int i = 23; i >= 0; i--) begin
            if (qual[i]) begin
                win_idx = 5'(i);
            end
        end
    end

    // Handshake FSM. irq_req is registered alongside the state so it is high
    // exactly in REQUEST and SERVICE. Leaving SERVICE always passes through
    // IDLE for at least one cycle, which gives the processor a low gap.
    always_comb begin
        state_d   = state_q;
        irq_req_d = irq_req_q;
        vector_d  = vector_q;
        case (state_q)
            IDLE: begin
                if (req_cond) begin
                    state_d   = REQUEST;
                    irq_req_d = 1'b1;
                    vector_d  = win_idx;
                end
            end
            REQUEST: begin
                if (bus.irq_ack) begin
                    state_d = SERVICE;
                end else if (!ctrl_q || !qual[vector_q]) begin
                    state_d   = IDLE;
                    irq_req_d = 1'b0;
                end
            end
            SERVICE: begin
                if (bus.irq_eoi) begin
                    state_d   = IDLE;
                    irq_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                irq_req_d = 1'b0;
            end
        endcase
    end

    // Register read mux, purely combinational from the address.
    always_comb begin
        rdata = '0;
        case (bus.reg_addr)
            3'd0:    rdata = pend_q[11:0];
            3'd1:    rdata = pend_q[23:12];
            3'd2:    rdata = en_q[11:0];
            3'd3:    rdata = en_q[23:12];
            3'd4:    rdata = (state_q == IDLE) ? 12'o7777 : {7'o0, vector_q};
            3'd5:    rdata = {11'd0, ctrl_q};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            arm_cnt_q <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            ctrl_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            arm_cnt_q <= arm_cnt_d;
            pend_q    <= pend_d;
            en_q      <= en_d;
            ctrl_q    <= ctrl_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
            vector_q  <= '0;
        end else begin
            state_q   <= state_d;
            irq_req_q <= irq_req_d;
            vector_q  <= vector_d;
        end
    end

    assign bus.reg_rdata  = rdata;
    assign bus.irq_req    = irq_req_q;
    assign bus.irq_vector = vector_q;

endmodule
